digit_display_ctrl: RTL
=======================

# digit_display_ctrl

Source controller for the six-digit seven-segment scanner. Shares the display between two requesters: a binary score, converted serially to BCD with leading-zero blanking, and a timed status message. Also drives the blink gating and the polarity line. It sits directly upstream of `digit_scan6` and drives all of that block's data and enable inputs. `digit_scan6` keeps its own scan clock and reset.

## Interface
- `TICK_DIV`, 50000: CLK cycles per display tick (1 ms at 50 MHz).
- `MSG_HOLD`, 2000: ticks a message stays on screen.
- `BLINK_TICKS`, 250: ticks per blink half-period.
- `DIS_POLARITY`, 1'b0: value driven on `DIS_STATE` (1 = common-anode inversion).
- `CLK`  in  1  system clock.
- `ASYNC_RST`  in  1  reset, asynchronous and active-high.
- `SCORE`  in  20  binary score.
- `SCORE_VALID`  in  1  one-cycle strobe; samples `SCORE`.
- `MSG_REQ`  in  1  level; request to show the message.
- `MSG_DIG`  in  24  six message nibbles; nibble 0 is the rightmost digit.
- `MSG_MASK`  in  6  per-digit enable for the message.
- `MSG_ACK`  out  1  one-cycle pulse when the message is latched.
- `BLINK_EN`  in  1  level; blink the whole display.
- `DIG`  out  24  nibbles to the scanner.
- `SEG_OEN`  out  6  per-digit enable to the scanner.
- `OEN`  out  1  global enable to the scanner.
- `DIS_STATE`  out  1  polarity to the scanner.
- `CONV_BUSY`  out  1  high while a BCD conversion is in progress.

## Operation
- **Reset values:**
  - `DIG` = 0
  - `SEG_OEN` = 6'b000001
  - `OEN` = 1
  - `DIS_STATE` = `DIS_POLARITY`
  - `MSG_ACK` = 0
  - `CONV_BUSY` = 0
  - tick, blink and hold counters = 0
  - score register = 0
  - both FSMs in their first state
- **Converter FSM (`C_IDLE` → `C_SHIFT` → `C_DONE` → `C_IDLE`):**
  - `SCORE_VALID` in `C_IDLE` latches `SCORE`, saturating values above 999999 to 999999.
  - `C_SHIFT` runs 20 shift-add-3 iterations, one per cycle.
  - `C_DONE` commits the 24-bit BCD result to the score register.
  - `SCORE_VALID` during `C_SHIFT` or `C_DONE` is stored as pending (last value wins). It starts a new conversion on the cycle after `C_DONE`. The in-flight result is still committed.
- **Leading-zero blanking (score only):**
  - Score `SEG_OEN[i]` = 1 iff any nibble j ≥ i is nonzero.
  - `SEG_OEN[0]` is always 1.
- **Display FSM, `D_SCORE`:**
  - Shows the score register with its blanking mask.
  - `MSG_REQ` high latches `MSG_DIG` and `MSG_MASK`, pulses `MSG_ACK`, clears the hold counter, and moves to `D_MSG`.
- **Display FSM, `D_MSG`:**
  - Shows the latched message.
  - Counts ticks; after `MSG_HOLD` ticks it returns to `D_SCORE`.
  - `MSG_REQ` is ignored and not acked while in `D_MSG`.
  - A request still high on return is acked on the cycle after the return.
- **Score commit while in `D_MSG`:** updates the score register invisibly; the new score is shown on return.
- **Blink:**
  - While `BLINK_EN` = 1, `OEN` toggles every `BLINK_TICKS` ticks, starting at 1.
  - When `BLINK_EN` falls, `OEN` goes to 1 the next cycle and the blink counter clears.
- **Tick prescaler:** free-runs and wraps at `TICK_DIV`-1; `tick` is high for one cycle at the wrap.

## Timing
- All outputs are registered.
- **Score path:** `SCORE_VALID` at cycle 0 → `CONV_BUSY` high cycles 1–21 → `DIG`/`SEG_OEN` updated at cycle 22 when in `D_SCORE`.
- **Message path:** `MSG_REQ` sampled at cycle 0 → `MSG_ACK`, `DIG` and `SEG_OEN` change at cycle 1.
- **Message end:** display returns to the score exactly `MSG_HOLD` ticks after the ack. Tick phase is not reset by the ack, so the hold error is at most one tick.
- **Simultaneous events:**
  - A commit and a message ack in the same cycle: the message is shown and the score is stored.
  - An expiring message and a new `MSG_REQ` in the same cycle: the score shows for one cycle, then the message is acked.
- **Reset mid-operation:** `ASYNC_RST` aborts a conversion, the message and blink immediately; all outputs take their reset values without waiting for a clock.

## Structure
- **Package `digit_disp_pkg`:**
  - converter and display state enums
  - `MAX_SCORE` = 999999
  - `SCORE_W` = 20
  - `BCD_W` = 24
  - `N_DIGITS` = 6
- **Sub-module `bin2bcd_serial`:**
  - ports: start, bin[19:0], busy, done pulse, bcd[23:0]
  - contains the converter FSM, saturation and pending logic
- **Top level:** prescaler, display FSM, blink logic and blanking.

## Test plan
The bench uses `TICK_DIV`=4, `MSG_HOLD`=3 and `BLINK_TICKS`=2.
- **Reset:** release reset → `DIG`=0, `SEG_OEN`=000001, `OEN`=1, `DIS_STATE`=`DIS_POLARITY`.
- **Conversion and blanking:** `SCORE`=2048 with a `SCORE_VALID` strobe → after 22 cycles `DIG`=24'h002048 and `SEG_OEN`=001111. `SCORE`=1048575 → `DIG`=24'h999999 and `SEG_OEN`=111111 (saturation).
- **Back-to-back strobes:** strobes with 5, then 7, then 9 while busy → two conversions run; final `DIG`=24'h000009 with no 7 left pending.
- **Message hold:** `MSG_REQ` with `MSG_DIG`=24'hABCDEF and `MSG_MASK`=110011 → `MSG_ACK` one cycle after the request; the message is held for 12 cycles ±4; then the score display returns. A second `MSG_REQ` held throughout is acked only after the return.
- **Blink:** `BLINK_EN`=1 → `OEN` period is 16 cycles; dropping `BLINK_EN` while `OEN`=0 → `OEN`=1 next cycle.
- **Reset mid-operation:** assert `ASYNC_RST` mid-conversion and again mid-message → outputs reach reset values before the next clock edge; `CONV_BUSY`=0.

Source files
------------

// File: rtl/digit_disp_pkg.sv
// Shared types and constants for the digit display controller.
//   - converter / display FSM state enums
//   - score and BCD widths, digit count, saturation limit
//   - blank_mask(): leading-zero blanking mask for a six-digit BCD value
package digit_disp_pkg;

    localparam int unsigned MAX_SCORE = 999999;
    localparam int unsigned SCORE_W   = 20;
    localparam int unsigned BCD_W     = 24;
    localparam int unsigned N_DIGITS  = 6;

    typedef enum logic [1:0] {
        C_IDLE,
        C_SHIFT,
        C_DONE
    } conv_state_e;

    typedef enum logic {
        D_SCORE,
        D_MSG
    } disp_state_e;

    // Digit i is lit iff some digit at or left of i is nonzero; the units digit is always lit
    // so that a zero score still shows "0".
    function automatic logic [N_DIGITS-1:0] blank_mask(input logic [BCD_W-1:0] bcd);
        logic [N_DIGITS-1:0] mask;
        logic                seen;
        mask = '0;
        seen = 1'b0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            seen    = seen | (bcd[4*i +: 4] != 4'd0);
            mask[i] = seen;
        end
        mask[0] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial binary-to-BCD converter (shift-add-3, one bit per cycle).
// Ports:
//   CLK, ASYNC_RST  clock, asynchronous active-high reset
//   start           one-cycle strobe sampling bin
//   bin[19:0]       binary input, saturated to 999999 on load
//   busy            registered, high from the cycle after load until the result is presented
//   done            one-cycle pulse while bcd holds a finished result
//   bcd[23:0]       six BCD digits, valid while done is high
// A start arriving while a conversion is in flight is parked (last one wins) and launched
// from idle on the cycle after the current result is presented.
module bin2bcd_serial
    import digit_disp_pkg::*;
(
    input  logic               CLK,
    input  logic               ASYNC_RST,
    input  logic               start,
    input  logic [SCORE_W-1:0] bin,
    output logic               busy,
    output logic               done,
    output logic [BCD_W-1:0]   bcd
);

    localparam logic [SCORE_W-1:0] MAX_BIN = SCORE_W'(MAX_SCORE);

    conv_state_e        state_q, state_d;
    logic [SCORE_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               pend_q, pend_d;
    logic [SCORE_W-1:0] pend_val_q, pend_val_d;
    logic               busy_q, busy_d;
    logic [BCD_W-1:0]   adj;
    logic [SCORE_W-1:0] load_val;

    // Add 3 to every digit >= 5 so the following doubling carries correctly into the next digit.
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // A fresh strobe in idle beats an older parked value.
    assign load_val = start ? bin : pend_val_q;

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;

        case (state_q)
            C_IDLE: begin
                if (start || pend_q) begin
                    bin_d   = (load_val > MAX_BIN) ? MAX_BIN : load_val;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                    state_d = C_SHIFT;
                end
            end
            C_SHIFT: begin
                {bcd_d, bin_d} = {adj, bin_q} << 1;
                cnt_d          = cnt_q + 5'd1;
                if (cnt_q == 5'(SCORE_W - 1)) begin
                    state_d = C_DONE;
                end
            end
            C_DONE: begin
                state_d = C_IDLE;
            end
            default: begin
                state_d = C_IDLE;
            end
        endcase

        if (start && (state_q != C_IDLE)) begin
            pend_d     = 1'b1;
            pend_val_d = bin;
        end

        busy_d = (state_d != C_IDLE);
    end

    always_ff @(posedge CLK or posedge ASYNC_RST) begin
        if (ASYNC_RST) begin
            state_q    <= C_IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            busy_q     <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = (state_q == C_DONE);
    assign bcd  = bcd_q;

endmodule

// File: rtl/digit_display_ctrl.sv
// Source controller for the six-digit seven-segment scanner.
// Arbitrates the display between a BCD-converted score (with leading-zero blanking) and a
// timed status message, and drives blink gating and the polarity line.
// Ports:
//   CLK, ASYNC_RST          clock, asynchronous active-high reset
//   SCORE, SCORE_VALID      binary score and its one-cycle load strobe
//   MSG_REQ                 level request to show MSG_DIG under MSG_MASK
//   MSG_DIG, MSG_MASK       message nibbles (nibble 0 rightmost) and per-digit enables
//   MSG_ACK                 one-cycle pulse when the message is latched
//   BLINK_EN                level; blink the whole display
//   DIG, SEG_OEN, OEN       nibbles, per-digit enables and global enable to the scanner
//   DIS_STATE               polarity line to the scanner
//   CONV_BUSY               high while a BCD conversion is running
module digit_display_ctrl
    import digit_disp_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned MSG_HOLD     = 2000,
    parameter int unsigned BLINK_TICKS  = 250,
    parameter logic        DIS_POLARITY = 1'b0
) (
    input  logic                CLK,
    input  logic                ASYNC_RST,
    input  logic [SCORE_W-1:0]  SCORE,
    input  logic                SCORE_VALID,
    input  logic                MSG_REQ,
    input  logic [BCD_W-1:0]    MSG_DIG,
    input  logic [N_DIGITS-1:0] MSG_MASK,
    output logic                MSG_ACK,
    input  logic                BLINK_EN,
    output logic [BCD_W-1:0]    DIG,
    output logic [N_DIGITS-1:0] SEG_OEN,
    output logic                OEN,
    output logic                DIS_STATE,
    output logic                CONV_BUSY
);

    localparam int unsigned TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned HOLD_W  = (MSG_HOLD > 1) ? $clog2(MSG_HOLD) : 1;
    localparam int unsigned BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic                tick;
    disp_state_e         disp_q, disp_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [BCD_W-1:0]    msg_dig_q, msg_dig_d;
    logic [N_DIGITS-1:0] msg_mask_q, msg_mask_d;
    logic                ack_q, ack_d;
    logic [BCD_W-1:0]    score_q, score_d;
    logic [BLINK_W-1:0]  blink_q, blink_d;
    logic                oen_q, oen_d;
    logic [BCD_W-1:0]    dig_q, dig_d;
    logic [N_DIGITS-1:0] seg_q, seg_d;
    logic                dis_q;
    logic                conv_busy;
    logic                conv_done;
    logic [BCD_W-1:0]    conv_bcd;

    bin2bcd_serial u_bin2bcd (
        .CLK       (CLK),
        .ASYNC_RST (ASYNC_RST),
        .start     (SCORE_VALID),
        .bin       (SCORE),
        .busy      (conv_busy),
        .done      (conv_done),
        .bcd       (conv_bcd)
    );

    // Free-running tick prescaler.
    assign tick       = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    // Score register takes commits regardless of what is currently on screen.
    assign score_d = conv_done ? conv_bcd : score_q;

    // Display FSM. MSG_REQ is only looked at in D_SCORE, so a request held across the return
    // shows the score for one cycle before it is acked again.
    always_comb begin
        disp_d     = disp_q;
        hold_d     = hold_q;
        msg_dig_d  = msg_dig_q;
        msg_mask_d = msg_mask_q;
        ack_d      = 1'b0;

        case (disp_q)
            D_SCORE: begin
                if (MSG_REQ) begin
                    msg_dig_d  = MSG_DIG;
                    msg_mask_d = MSG_MASK;
                    hold_d     = '0;
                    ack_d      = 1'b1;
                    disp_d     = D_MSG;
                end
            end
            D_MSG: begin
                if (tick) begin
                    if (hold_q == HOLD_W'(MSG_HOLD - 1)) begin
                        hold_d = '0;
                        disp_d = D_SCORE;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            default: begin
                disp_d = D_SCORE;
            end
        endcase
    end

    // Output image is built from next-state values so DIG/SEG_OEN move together with the
    // state change instead of one cycle behind it.
    always_comb begin
        if (disp_d == D_MSG) begin
            dig_d = msg_dig_d;
            seg_d = msg_mask_d;
        end else begin
            dig_d = score_d;
            seg_d = blank_mask(score_d);
        end
    end

    // Blink: OEN starts high and toggles every BLINK_TICKS ticks while enabled.
    always_comb begin
        oen_d   = oen_q;
        blink_d = blink_q;
        if (!BLINK_EN) begin
            oen_d   = 1'b1;
            blink_d = '0;
        end else if (tick) begin
            if (blink_q == BLINK_W'(BLINK_TICKS - 1)) begin
                blink_d = '0;
                oen_d   = ~oen_q;
            end else begin
                blink_d = blink_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge ASYNC_RST) begin
        if (ASYNC_RST) begin
            tick_cnt_q <= '0;
            disp_q     <= D_SCORE;
            hold_q     <= '0;
            msg_dig_q  <= '0;
            msg_mask_q <= '0;
            ack_q      <= 1'b0;
            score_q    <= '0;
            blink_q    <= '0;
            oen_q      <= 1'b1;
            dig_q      <= '0;
            seg_q      <= N_DIGITS'(1);
            dis_q      <= DIS_POLARITY;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            disp_q     <= disp_d;
            hold_q     <= hold_d;
            msg_dig_q  <= msg_dig_d;
            msg_mask_q <= msg_mask_d;
            ack_q      <= ack_d;
            score_q    <= score_d;
            blink_q    <= blink_d;
            oen_q      <= oen_d;
            dig_q      <= dig_d;
            seg_q      <= seg_d;
            dis_q      <= DIS_POLARITY;
        end
    end

    assign DIG       = dig_q;
    assign SEG_OEN   = seg_q;
    assign OEN       = oen_q;
    assign DIS_STATE = dis_q;
    assign MSG_ACK   = ack_q;
    assign CONV_BUSY = conv_busy;

endmodule
